bcd_counter: RTL

- Parametrised multi-digit packed-BCD up/down counter; the registered successor of the team's 3-digit combinational BCD incrementor.
- Supports synchronous load with BCD validity checking, enable, direction control, and wrap/borrow indication.
- Sits in display and timekeeping datapaths.
- Its carry_out drives the enable of a cascaded counter.

---
 rtl/bcd_pkg.sv | 25 ++
 rtl/bcd_digit.sv | 46 ++++
 rtl/bcd_counter.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/bcd_pkg.sv
// ---------------------------------------------------------------------------
// bcd_pkg
// Shared types, constants and helpers for the packed-BCD counter datapath.
//   bcd_digit_t : one packed-BCD nibble
//   bcd_dir_e   : count direction encoding (matches the 'up' control bit)
//   BCD_MAX/MIN : legal nibble range
//   bcd_valid() : 1 when a nibble holds a legal BCD digit (0..9)
// ---------------------------------------------------------------------------
package bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } bcd_dir_e;

    localparam bcd_digit_t BCD_MAX = 4'd9;
    localparam bcd_digit_t BCD_MIN = 4'd0;

    function automatic logic bcd_valid(input bcd_digit_t d);
        return (d <= BCD_MAX);
    endfunction

endpackage : bcd_pkg

// File: rtl/bcd_digit.sv
// ---------------------------------------------------------------------------
// bcd_digit
// Purely combinational single-digit BCD step cell. When cin_i is high the
// digit moves one step in the direction selected by up_i, generating a
// carry (up, 9->0) or borrow (down, 0->9) on cout_o. With cin_i low the
// digit passes through unchanged and cout_o is low.
// Ports:
//   cin_i   : carry/borrow in from the next-lower digit
//   up_i    : 1 = increment, 0 = decrement
//   digit_i : current digit value (0..9)
//   digit_o : next digit value
//   cout_o  : carry/borrow out to the next-higher digit
// ---------------------------------------------------------------------------
module bcd_digit
    import bcd_pkg::*;
(
    input  logic       cin_i,
    input  logic       up_i,
    input  bcd_digit_t digit_i,
    output bcd_digit_t digit_o,
    output logic       cout_o
);

    always_comb begin
        digit_o = digit_i;
        cout_o  = 1'b0;
        if (cin_i) begin
            if (bcd_dir_e'(up_i) == DIR_UP) begin
                if (digit_i >= BCD_MAX) begin
                    digit_o = BCD_MIN;
                    cout_o  = 1'b1;
                end else begin
                    digit_o = digit_i + 4'd1;
                end
            end else begin
                if (digit_i == BCD_MIN) begin
                    digit_o = BCD_MAX;
                    cout_o  = 1'b1;
                end else begin
                    digit_o = digit_i - 4'd1;
                end
            end
        end
    end

endmodule : bcd_digit

// File: rtl/bcd_counter.sv
// ---------------------------------------------------------------------------
// bcd_counter
// Parametrised multi-digit packed-BCD up/down counter with synchronous
// validated load, enable, direction control and wrap/borrow pulse.
// Parameters:
//   DIGITS    : number of BCD digits (>=1); bus width is 4*DIGITS
//   RESET_VAL : packed-BCD reset value; every nibble must be <=9
// Ports:
//   clk       : rising-edge clock
//   rst_n     : asynchronous active-low reset
//   en        : count enable, one step per cycle
//   up        : 1 = increment, 0 = decrement
//   load      : synchronous load request (priority over en)
//   load_val  : packed-BCD load value, digit 0 in bits [3:0]
//   bcd_out   : registered count value
//   carry_out : registered one-cycle pulse on wrap (up) / borrow (down)
//   load_err  : registered one-cycle pulse when a load is rejected
//   at_max    : all digits are 9 (combinational from bcd_out)
//   at_min    : all digits are 0 (combinational from bcd_out)
// Build option:
//   BCD_COUNTER_SATURATE_EN : when defined, the counter pins at all-9
//   (up) / all-0 (down) instead of wrapping, and carry_out pulses on every
//   blocked step.
// ---------------------------------------------------------------------------
module bcd_counter
    import bcd_pkg::*;
#(
    parameter int unsigned             DIGITS    = 3,
    parameter logic [4*DIGITS-1:0]     RESET_VAL = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  up,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  carry_out,
    output logic                  load_err,
    output logic                  at_max,
    output logic                  at_min
);

    localparam int unsigned W = 4 * DIGITS;

    // Elaboration-time guard: an illegal reset nibble would put the
    // counter in a state the digit cells never produce.
    if (DIGITS < 1) begin : g_bad_digits
        $fatal(1, "bcd_counter: DIGITS must be >= 1");
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_rst_chk
        if (RESET_VAL[4*g +: 4] > 4'd9) begin : g_bad_nibble
            $fatal(1, "bcd_counter: RESET_VAL nibble %0d is not BCD", g);
        end
    end

    logic [W-1:0] count_q, count_d;
    logic         carry_q, carry_d;
    logic         err_q,   err_d;

    // Ripple chain: digit 0 always receives a step request; the output
    // of the top digit flags a full wrap/borrow across all digits.
    logic [DIGITS:0] chain;
    logic [W-1:0]    step_val;

    assign chain[0] = 1'b1;

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_digit u_digit (
            .cin_i   (chain[g]),
            .up_i    (up),
            .digit_i (count_q[4*g +: 4]),
            .digit_o (step_val[4*g +: 4]),
            .cout_o  (chain[g+1])
        );
    end

    logic load_ok;

    always_comb begin
        load_ok = 1'b1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (!bcd_valid(load_val[4*i +: 4])) begin
                load_ok = 1'b0;
            end
        end
    end

    always_comb begin
        count_d = count_q;
        carry_d = 1'b0;
        err_d   = 1'b0;
        if (load) begin
            if (load_ok) begin
                count_d = load_val;
            end else begin
                err_d = 1'b1;
            end
        end else if (en) begin
`ifdef BCD_COUNTER_SATURATE_EN
            // A full-width carry means the step would leave the range:
            // hold the pinned value and report the blocked step.
            if (chain[DIGITS]) begin
                carry_d = 1'b1;
            end else begin
                count_d = step_val;
            end
`else
            count_d = step_val;
            carry_d = chain[DIGITS];
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= RESET_VAL;
            carry_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            carry_q <= carry_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        at_max = 1'b1;
        at_min = 1'b1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (count_q[4*i +: 4] != BCD_MAX) at_max = 1'b0;
            if (count_q[4*i +: 4] != BCD_MIN) at_min = 1'b0;
        end
    end

    assign bcd_out   = count_q;
    assign carry_out = carry_q;
    assign load_err  = err_q;

endmodule : bcd_counter
